// File: rtl/joy_serial_scan.sv
// Scanner for a daisy-chained 74HC165-style joystick chain: load, shift out PLAYERS*BITS bits,
// debounce whole frames and present one button bus per player (1 = pressed).
module joy_serial_scan #(
   parameter int DIV        = 24,
   parameter int PLAYERS    = 2,
   parameter int BITS       = 16,
   parameter int GAP        = 1024,
   parameter int DEBOUNCE   = 2,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                      clk,
   input  logic                      RESET_N,
   input  logic                      enable,
   input  logic                      JOY_DATA,
   output logic                      JOY_CLK,
   output logic                      JOY_LOAD,
   output logic [PLAYERS*BITS-1:0]   joystick,
   output logic                      frame_stb,
   output logic                      changed
);

   localparam int TOTAL = PLAYERS * BITS;
   localparam int KW    = (TOTAL > 1)    ? $clog2(TOTAL)    : 1;
   localparam int DW    = (DIV > 1)      ? $clog2(DIV)      : 1;
   localparam int GW    = (GAP > 1)      ? $clog2(GAP)      : 1;
   localparam int CW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
   localparam logic [KW-1:0] K_LAST   = KW'(TOTAL - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_SHIFT_LO = 3'd2;
   localparam logic [2:0] S_SHIFT_HI = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;
   localparam logic [2:0] S_GAPW     = 3'd5;

   logic             r_rst_meta;
   logic             r_rst_sync;
   logic             r_data_meta;
   logic             r_data_sync;
   logic [2:0]       r_state;
   logic [DW-1:0]    r_div;
   logic [GW-1:0]    r_gap;
   logic [KW-1:0]    r_k;
   logic [TOTAL-1:0] r_raw;
   logic [TOTAL-1:0] r_prev;
   logic [CW-1:0]    r_cnt;
   logic [TOTAL-1:0] r_joy;
   logic             r_joy_clk;
   logic             r_joy_load;
   logic             r_stb;
   logic             r_changed;

   logic             w_rst_n;
   logic             w_div_last;
   logic             w_gap_last;
   logic             w_k_last;
   logic [CW-1:0]    w_cnt_next;
   logic             w_commit;

   assign w_rst_n    = r_rst_sync;
   assign w_div_last = (r_div == DIV_LAST);
   assign w_gap_last = (r_gap == GAP_LAST);
   assign w_k_last   = (r_k == K_LAST);

   assign JOY_CLK   = r_joy_clk;
   assign JOY_LOAD  = r_joy_load;
   assign joystick  = r_joy;
   assign frame_stb = r_stb;
   assign changed   = r_changed;

   // Reset asserts immediately, releases two clocks after RESET_N rises
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   // Two-flop synchroniser on the chain data pin
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_data_meta <= 1'b0;
         r_data_sync <= 1'b0;
      end else begin
         r_data_meta <= JOY_DATA;
         r_data_sync <= r_data_meta;
      end
   end

   // Next debounce count: saturate on a repeated frame, restart on any difference
   always_comb begin
      w_cnt_next = '0;
      if (r_raw != r_prev) begin
         w_cnt_next = '0;
      end else if (r_cnt == CNT_MAX) begin
         w_cnt_next = CNT_MAX;
      end else begin
         w_cnt_next = r_cnt + CW'(1);
      end
   end

   assign w_commit = (w_cnt_next == CNT_MAX) && (r_raw != r_joy);

   // Frame sequencer; pin levels are registered alongside the state they belong to
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= S_IDLE;
         r_div      <= '0;
         r_gap      <= '0;
         r_k        <= '0;
         r_joy_clk  <= 1'b1;
         r_joy_load <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_div <= '0;
               if (enable) begin
                  r_state    <= S_LOAD;
                  r_joy_load <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_LOAD: begin
               if (w_div_last) begin
                  r_div      <= '0;
                  r_k        <= '0;
                  r_joy_load <= 1'b1;
                  r_joy_clk  <= 1'b0;
                  r_state    <= S_SHIFT_LO;
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            S_SHIFT_LO: begin
               if (w_div_last) begin
                  r_div     <= '0;
                  r_joy_clk <= 1'b1;
                  r_state   <= S_SHIFT_HI;
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            S_SHIFT_HI: begin
               if (!w_div_last) begin
                  r_div <= r_div + DW'(1);
               end else if (w_k_last) begin
                  r_div   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_div     <= '0;
                  r_k       <= r_k + KW'(1);
                  r_joy_clk <= 1'b0;
                  r_state   <= S_SHIFT_LO;
               end
            end
            S_DONE: begin
               r_gap   <= '0;
               r_state <= S_GAPW;
            end
            S_GAPW: begin
               if (!w_gap_last) begin
                  r_gap <= r_gap + GW'(1);
               end else if (enable) begin
                  r_joy_load <= 1'b0;
                  r_state    <= S_LOAD;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_div      <= '0;
               r_joy_clk  <= 1'b1;
               r_joy_load <= 1'b1;
            end
         endcase
      end
   end

   // Bit capture and frame-level debounce; only a completed frame reaches DONE
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_raw     <= '0;
         r_prev    <= '0;
         r_cnt     <= '0;
         r_joy     <= '0;
         r_stb     <= 1'b0;
         r_changed <= 1'b0;
      end else begin
         r_stb     <= 1'b0;
         r_changed <= 1'b0;
         if ((r_state == S_SHIFT_LO) && w_div_last) begin
            r_raw[r_k] <= r_data_sync ^ ACTIVE_LOW;
         end else if (r_state == S_DONE) begin
            r_stb  <= 1'b1;
            r_cnt  <= w_cnt_next;
            r_prev <= r_raw;
            if (w_commit) begin
               r_joy     <= r_raw;
               r_changed <= 1'b1;
            end else begin
               r_joy <= r_joy;
            end
         end else begin
            r_raw <= r_raw;
         end
      end
   end

endmodule

// File: tb/tb_joy_serial_scan.sv
// Scoreboard bench: a 74HC165 chain model feeds directed frames; a monitor checks every
// frame_stb against queued expectations and measures pin timing.
module tb_joy_serial_scan;

   localparam int DIV      = 4;
   localparam int PLAYERS  = 2;
   localparam int BITS     = 16;
   localparam int GAP      = 10;
   localparam int DEBOUNCE = 2;
   localparam int TOTAL    = PLAYERS * BITS;
   localparam int PERIOD   = DIV + 2 * DIV * TOTAL + 1 + GAP;

   logic             clk;
   logic             RESET_N;
   logic             enable;
   logic             JOY_DATA;
   logic             JOY_CLK;
   logic             JOY_LOAD;
   logic [TOTAL-1:0] joystick;
   logic             frame_stb;
   logic             changed;

   int n_checks = 0;
   int n_fail   = 0;

   logic [TOTAL-1:0] pins;
   logic [TOTAL:0]   exp_q[$];
   logic [TOTAL-1:0] vec_raw[$];
   logic [TOTAL-1:0] vec_joy[$];
   logic             vec_ch[$];
   logic             timing_chk;
   logic             period_chk;

   joy_serial_scan #(
      .DIV(DIV), .PLAYERS(PLAYERS), .BITS(BITS), .GAP(GAP),
      .DEBOUNCE(DEBOUNCE), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .RESET_N(RESET_N), .enable(enable), .JOY_DATA(JOY_DATA),
      .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .joystick(joystick),
      .frame_stb(frame_stb), .changed(changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Chain model: parallel load while JOY_LOAD low, shift on JOY_CLK rising, pins idle high
   initial begin
      logic [TOTAL-1:0] shreg;
      logic             clk_q;
      shreg    = '1;
      clk_q    = 1'b1;
      JOY_DATA = 1'b1;
      forever begin
         @(negedge clk);
         if (!JOY_LOAD) shreg = pins;
         else if (JOY_CLK && !clk_q) shreg = {1'b1, shreg[TOTAL-1:1]};
         clk_q    = JOY_CLK;
         JOY_DATA = shreg[0];
      end
   end

   // Monitor: scoreboard pops on frame_stb plus pin pulse-width and frame-period checks
   initial begin
      int cyc = 0;
      int load_lo = 0;
      int clk_lo = 0;
      int pulses = 0;
      int last_stb = -1;
      logic [TOTAL:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!timing_chk) begin
            load_lo = 0; clk_lo = 0; pulses = 0;
         end else begin
            if (!JOY_LOAD) load_lo++;
            else if (load_lo != 0) begin
               check("load_low_width", load_lo, DIV);
               load_lo = 0;
               pulses  = 0;
            end
            if (!JOY_CLK) clk_lo++;
            else if (clk_lo != 0) begin
               check("clk_low_width", clk_lo, DIV);
               clk_lo = 0;
               pulses++;
            end
         end
         if (changed && !frame_stb) check("changed_without_stb", 1, 0);
         if (frame_stb) begin
            if (timing_chk) check("clk_pulses_per_frame", pulses, TOTAL);
            pulses = 0;
            if (period_chk && last_stb >= 0) check("frame_period", cyc - last_stb, PERIOD);
            last_stb = period_chk ? cyc : -1;
            if (exp_q.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("joystick", joystick, e[TOTAL-1:0]);
               check("changed", changed, e[TOTAL]);
            end
         end
      end
   end

   task automatic wait_stb(input int lim, input string nm);
      int c = 0;
      logic seen = 1'b0;
      while (!seen && c < lim) begin
         @(negedge clk);
         c++;
         seen = frame_stb;
      end
      check(nm, seen, 1);
   endtask

   task automatic wait_falls(input int n, input int lim, input string nm);
      int c = 0;
      int seen = 0;
      logic prev;
      prev = JOY_CLK;
      while (seen < n && c < lim) begin
         @(negedge clk);
         c++;
         if (prev && !JOY_CLK) seen++;
         prev = JOY_CLK;
      end
      check(nm, seen, n);
   endtask

   task automatic add_vec(input logic [TOTAL-1:0] raw, input logic [TOTAL-1:0] joy, input logic ch);
      vec_raw.push_back(raw);
      vec_joy.push_back(joy);
      vec_ch.push_back(ch);
   endtask

   initial begin
      logic [TOTAL-1:0] m_v, a_v, b_v, c_v, d_v;
      int bad;
      int lo_cnt, ck_cnt, stb_cnt;
      m_v = 32'h8000_0001; a_v = 32'h0000_00FF; b_v = 32'h1234_5678;
      c_v = 32'h00F0_0F00; d_v = 32'hFFFF_0000;
      RESET_N = 1'b0; enable = 1'b0; pins = '1;
      timing_chk = 1'b1; period_chk = 1'b0;

      repeat (5) @(negedge clk);
      check("rst_joy_clk", JOY_CLK, 1);
      check("rst_joy_load", JOY_LOAD, 1);
      check("rst_joystick", joystick, 0);
      check("rst_frame_stb", frame_stb, 0);
      check("rst_changed", changed, 0);
      RESET_N = 1'b1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!JOY_CLK || !JOY_LOAD || frame_stb || joystick != 0) bad++;
      end
      check("idle_quiet", bad, 0);

      // pins 0xFFFE / 0x7FFF give pressed 0x0001 / 0x8000
      add_vec(m_v, 32'h0,  1'b0);
      add_vec(m_v, m_v,    1'b1);
      add_vec(m_v, m_v,    1'b0);
      for (int i = 0; i < 6; i++) add_vec((i % 2 == 0) ? a_v : b_v, m_v, 1'b0);
      add_vec(c_v, m_v, 1'b0);
      add_vec(c_v, c_v, 1'b1);
      add_vec(c_v, c_v, 1'b0);
      add_vec(d_v, c_v, 1'b0);
      add_vec(d_v, d_v, 1'b1);

      period_chk = 1'b1;
      for (int i = 0; i < vec_raw.size(); i++) begin
         pins = ~vec_raw[i];
         exp_q.push_back({vec_ch[i], vec_joy[i]});
         if (i == 0) enable = 1'b1;
         wait_stb(2 * PERIOD, "stb_timeout_main");
      end

      // Enable dropped at bit 10: frame still completes, then idle
      exp_q.push_back({1'b0, d_v});
      wait_falls(11, 2 * PERIOD, "reach_bit10");
      enable = 1'b0;
      wait_stb(2 * PERIOD, "stb_timeout_drop");
      period_chk = 1'b0;
      lo_cnt = 0; ck_cnt = 0; stb_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!JOY_LOAD) lo_cnt++;
         if (i > GAP && !JOY_CLK) ck_cnt++;
         if (frame_stb) stb_cnt++;
      end
      check("drop_no_load", lo_cnt, 0);
      check("drop_clk_high", ck_cnt, 0);
      check("drop_no_stb", stb_cnt, 0);

      // Reset in the middle of bit 20
      enable = 1'b1;
      wait_falls(21, 2 * PERIOD, "reach_bit20");
      timing_chk = 1'b0;
      RESET_N = 1'b0;
      #1;
      check("midrst_joystick", joystick, 0);
      check("midrst_joy_clk", JOY_CLK, 1);
      check("midrst_joy_load", JOY_LOAD, 1);
      check("midrst_changed", changed, 0);
      repeat (3) @(negedge clk);
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b1, d_v});
      RESET_N = 1'b1;
      timing_chk = 1'b1;
      wait_stb(2 * PERIOD, "stb_timeout_rst1");
      wait_stb(2 * PERIOD, "stb_timeout_rst2");

      enable = 1'b0;
      repeat (20) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
